// File: rtl/core_run_ctrl_pkg.sv
// core_run_pkg: shared types and constants for the core run sequencer.
//   run_state_t   - sequencer state encoding
//   CYCLE_COUNT_W - width of the saturating run-cycle counter
//   max3          - constant helper for sizing the shared dwell counter
package core_run_pkg;

  localparam int unsigned CYCLE_COUNT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    SETTLE,
    LAUNCH,
    RUN,
    DRAIN,
    DONE,
    TIMEOUT
  } run_state_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/core_run_ctrl_up_counter.sv
// UpCounter: free-running up counter with synchronous clear and enable.
//   clk    - clock
//   rstn   - asynchronous active-low reset
//   en     - advance by INCREMENT_RATE this cycle
//   clear  - synchronous clear to zero (wins over en)
//   count  - current value, wraps at WIDTH bits
module UpCounter #(
  parameter int unsigned INCREMENT_RATE = 1,
  parameter int unsigned WIDTH          = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(INCREMENT_RATE);
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run sequencer for CoreTop. On start it holds the core in
// reset, opens the clock gate, fires a one-cycle fetch trigger, then
// supervises the run with a kickable watchdog until halt or expiry.
//   clk, rst            - clock, asynchronous active-high reset
//   start               - run request pulse (ignored while busy)
//   halt_req            - core halted (EBREAK/ECALL), honoured in RUN only
//   wd_kick             - core progress pulse, clears the watchdog
//   core_rstn           - active-low reset to CoreTop
//   cg_clk_en           - ClockGate enable
//   first_fetch_trigger - one-cycle launch pulse
//   busy                - not in IDLE, DONE or TIMEOUT
//   done, timeout       - sticky end-of-run flags
//   cycle_count         - RUN+DRAIN cycles, saturating
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 10,
  parameter int unsigned SETTLE_CYCLES = 10,
  parameter int unsigned DRAIN_CYCLES  = 4,
  parameter int unsigned WATCHDOG_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     halt_req,
  input  logic                     wd_kick,
  output logic                     core_rstn,
  output logic                     cg_clk_en,
  output logic                     first_fetch_trigger,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic [CYCLE_COUNT_W-1:0] cycle_count
);

  localparam int unsigned DWELL_MAX = max3(RESET_CYCLES, SETTLE_CYCLES, DRAIN_CYCLES);
  localparam int unsigned DWELL_W   = $clog2(DWELL_MAX + 1);

  // Dwell counter counts down from N-1 so a state lasts exactly N cycles.
  localparam logic [DWELL_W-1:0] RESET_LOAD  = DWELL_W'(RESET_CYCLES - 1);
  localparam logic [DWELL_W-1:0] SETTLE_LOAD = DWELL_W'(SETTLE_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DRAIN_LOAD  = DWELL_W'(DRAIN_CYCLES - 1);

  run_state_t               state, state_n;
  logic [DWELL_W-1:0]       dwell, dwell_n;
  logic [WATCHDOG_W-1:0]    wd_count;
  logic                     wd_expired;
  logic                     core_rstn_n, cg_clk_en_n, trigger_n, busy_n, done_n, timeout_n;
  logic [CYCLE_COUNT_W-1:0] cycle_count_n;

  UpCounter #(
    .INCREMENT_RATE (1),
    .WIDTH          (WATCHDOG_W)
  ) u_watchdog (
    .clk   (clk),
    .rstn  (~rst),
    .en    (state == RUN),
    .clear (wd_kick || (state == LAUNCH)),
    .count (wd_count)
  );

  assign wd_expired = &wd_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      dwell               <= '0;
      core_rstn           <= 1'b0;
      cg_clk_en           <= 1'b0;
      first_fetch_trigger <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      timeout             <= 1'b0;
      cycle_count         <= '0;
    end else begin
      state               <= state_n;
      dwell               <= dwell_n;
      core_rstn           <= core_rstn_n;
      cg_clk_en           <= cg_clk_en_n;
      first_fetch_trigger <= trigger_n;
      busy                <= busy_n;
      done                <= done_n;
      timeout             <= timeout_n;
      cycle_count         <= cycle_count_n;
    end
  end

  always_comb begin
    state_n       = state;
    dwell_n       = dwell;
    cycle_count_n = cycle_count;

    case (state)
      IDLE, DONE, TIMEOUT: begin
        if (start) begin
          state_n       = RESET;
          dwell_n       = RESET_LOAD;
          cycle_count_n = '0;
        end
      end
      RESET: begin
        if (dwell == '0) begin
          state_n = SETTLE;
          dwell_n = SETTLE_LOAD;
        end else begin
          dwell_n = dwell - DWELL_W'(1);
        end
      end
      SETTLE: begin
        if (dwell == '0) begin
          state_n = LAUNCH;
        end else begin
          dwell_n = dwell - DWELL_W'(1);
        end
      end
      LAUNCH: begin
        state_n = RUN;
      end
      RUN: begin
        // halt wins over both a kick and expiry in the same cycle
        if (halt_req) begin
          state_n = DRAIN;
          dwell_n = DRAIN_LOAD;
        end else if (wd_expired && !wd_kick) begin
          state_n = TIMEOUT;
        end
      end
      DRAIN: begin
        if (dwell == '0) begin
          state_n = DONE;
        end else begin
          dwell_n = dwell - DWELL_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (((state == RUN) || (state == DRAIN)) && (cycle_count != '1)) begin
      cycle_count_n = cycle_count + CYCLE_COUNT_W'(1);
    end

    // Outputs are decoded from the next state and registered alongside it.
    core_rstn_n = (state_n != IDLE) && (state_n != RESET);
    cg_clk_en_n = (state_n == SETTLE) || (state_n == LAUNCH) ||
                  (state_n == RUN)    || (state_n == DRAIN);
    trigger_n   = (state_n == LAUNCH);
    busy_n      = (state_n != IDLE) && (state_n != DONE) && (state_n != TIMEOUT);
    done_n      = (state_n == DONE);
    timeout_n   = (state_n == TIMEOUT);
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl (defaults except WATCHDOG_W=4).
// Expected output vectors come from the cycle-level timeline of a run:
// start sampled at edge 0, observations after edge c-1 belong to cycle c.
module tb_core_run_ctrl;

  localparam int R  = 10;
  localparam int S  = 10;
  localparam int D  = 4;
  localparam int WW = 4;
  localparam int WD = 1 << WW;
  localparam int E  = R + S + 2;  // first RUN cycle

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        wd_kick = 1'b0;
  logic        core_rstn, cg_clk_en, first_fetch_trigger, busy, done, timeout;
  logic [31:0] cycle_count;

  int n_vec = 0;
  int n_err = 0;
  logic [37:0] sb[$];

  core_run_ctrl #(
    .RESET_CYCLES  (R),
    .SETTLE_CYCLES (S),
    .DRAIN_CYCLES  (D),
    .WATCHDOG_W    (WW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .halt_req            (halt_req),
    .wd_kick             (wd_kick),
    .core_rstn           (core_rstn),
    .cg_clk_en           (cg_clk_en),
    .first_fetch_trigger (first_fetch_trigger),
    .busy                (busy),
    .done                (done),
    .timeout             (timeout),
    .cycle_count         (cycle_count)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] observe();
    return {core_rstn, cg_clk_en, first_fetch_trigger, busy, done, timeout, cycle_count};
  endfunction

  // Expected outputs in cycle c of a run that enters DONE/TIMEOUT at end_c.
  function automatic logic [37:0] exp_vec(input int c, input int end_c, input bit by_halt);
    logic        e_rstn, e_cg, e_trig, e_busy, e_done, e_to;
    int          cnt;
    e_rstn = (c >= R + 1);
    e_cg   = (c >= R + 1) && (c < end_c);
    e_trig = (c == R + S + 1);
    e_busy = (c >= 1) && (c < end_c);
    e_done = by_halt && (c >= end_c);
    e_to   = !by_halt && (c >= end_c);
    if (c <= E)          cnt = 0;
    else if (c >= end_c) cnt = end_c - E;
    else                 cnt = c - E;
    return {e_rstn, e_cg, e_trig, e_busy, e_done, e_to, 32'(cnt)};
  endfunction

  // Drive the inputs sampled at edge c, queue the expectation for cycle c+1,
  // then advance to just after that edge.
  task automatic drive_cycle(input int c, input int h, input int kp, input bit noise,
                             input int end_c, input bit by_halt);
    start    = (c == 0) || (noise && (c < end_c) && (c % 3 == 0));
    halt_req = (h > 0 && c == h) || (noise && (c < E || c >= end_c));
    wd_kick  = (kp > 0 && c >= E && ((c - E) % kp) == kp - 1) ||
               (noise && (c < E || c >= end_c));
    sb.push_back(exp_vec(c + 1, end_c, by_halt));
    @(posedge clk);
    #1;
    start    = 1'b0;
    halt_req = 1'b0;
    wd_kick  = 1'b0;
  endtask

  task automatic test_reset();
    logic [37:0] exp, obs;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back('0);
    exp = sb.pop_front(); obs = observe(); n_vec++;
    if (obs !== exp) begin
      n_err++; $display("FAIL reset_state: got %h expected %h", obs, exp);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      halt_req = 1'b1;
      wd_kick  = 1'b1;
      sb.push_back(exp_vec(0, 1000, 1'b0));
      @(posedge clk);
      #1;
      halt_req = 1'b0;
      wd_kick  = 1'b0;
      exp = sb.pop_front(); obs = observe(); n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL idle_hold %0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_bringup_halt();
    logic [37:0] exp, obs;
    int h = E + 5;
    int end_c = h + D + 1;
    for (int c = 0; c < end_c + 2; c++) begin
      drive_cycle(c, h, 0, 1'b0, end_c, 1'b1);
      exp = sb.pop_front(); obs = observe(); n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL bringup_halt cycle %0d: got %h expected %h", c + 1, obs, exp);
      end
    end
  endtask

  task automatic test_timeout();
    logic [37:0] exp, obs;
    int end_c = E + WD;
    for (int c = 0; c < end_c + 2; c++) begin
      drive_cycle(c, 0, 0, 1'b0, end_c, 1'b0);
      exp = sb.pop_front(); obs = observe(); n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL timeout cycle %0d: got %h expected %h", c + 1, obs, exp);
      end
    end
  endtask

  task automatic test_kick();
    logic [37:0] exp, obs;
    int h = E + 60;
    int end_c = h + D + 1;
    for (int c = 0; c < end_c + 2; c++) begin
      drive_cycle(c, h, 10, 1'b0, end_c, 1'b1);
      exp = sb.pop_front(); obs = observe(); n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL kick cycle %0d: got %h expected %h", c + 1, obs, exp);
      end
    end
  endtask

  task automatic test_halt_at_expiry();
    logic [37:0] exp, obs;
    int h = E + WD - 1;  // watchdog is all-ones in this cycle
    int end_c = h + D + 1;
    for (int c = 0; c < end_c + 2; c++) begin
      drive_cycle(c, h, 0, 1'b0, end_c, 1'b1);
      exp = sb.pop_front(); obs = observe(); n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL halt_at_expiry cycle %0d: got %h expected %h", c + 1, obs, exp);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [37:0] exp, obs;
    int h = E + 8;
    int end_c = h + D + 1;
    for (int c = 0; c < end_c + 2; c++) begin
      drive_cycle(c, h, 0, 1'b1, end_c, 1'b1);
      exp = sb.pop_front(); obs = observe(); n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL start_while_busy cycle %0d: got %h expected %h", c + 1, obs, exp);
      end
    end
  endtask

  task automatic test_rst_mid_run();
    logic [37:0] exp, obs;
    int h = E + 3;
    int end_c = h + D + 1;
    for (int c = 0; c < E + 8; c++) begin
      drive_cycle(c, 0, 0, 1'b0, E + WD, 1'b0);
      exp = sb.pop_front(); obs = observe(); n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL pre_rst_run cycle %0d: got %h expected %h", c + 1, obs, exp);
      end
    end
    rst = 1'b1;
    sb.push_back('0);
    #1;
    exp = sb.pop_front(); obs = observe(); n_vec++;
    if (obs !== exp) begin
      n_err++; $display("FAIL async_rst_immediate: got %h expected %h", obs, exp);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < end_c + 2; c++) begin
      drive_cycle(c, h, 0, 1'b0, end_c, 1'b1);
      exp = sb.pop_front(); obs = observe(); n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL restart_after_rst cycle %0d: got %h expected %h", c + 1, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bringup_halt();
    test_timeout();
    test_kick();
    test_halt_at_expiry();
    test_start_while_busy();
    test_rst_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Synthesizable run sequencer that brings up and supervises `CoreTop`, sitting directly upstream of it. On a `start` pulse it:
- holds the core in reset;
- opens the core clock gate;
- issues the single-cycle `first_fetch_trigger`;
- supervises execution with a kickable watchdog.

It ends the run on a core halt request (`done`) or on watchdog expiry (`timeout`), then closes the clock gate so data memory can be dumped. It replaces the hand-timed bring-up sequence with a deterministic, cycle-exact one.

## Interface
Parameters:
- `RESET_CYCLES`, 10 — cycles `core_rstn` is held low.
- `SETTLE_CYCLES`, 10 — cycles between gate open and fetch trigger.
- `DRAIN_CYCLES`, 4 — cycles the clock stays on after a halt so in-flight stores commit.
- `WATCHDOG_W`, 8 — watchdog width; expiry after 2^WATCHDOG_W idle RUN cycles.

Ports:
- `clk` in 1 — free-running clock. One clock; all logic on its rising edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `start` in 1 — run request pulse.
- `halt_req` in 1 — core retired EBREAK/ECALL.
- `wd_kick` in 1 — core progress pulse (instruction retired).
- `core_rstn` out 1 — active-low reset to `CoreTop`.
- `cg_clk_en` out 1 — enable to `ClockGate`.
- `first_fetch_trigger` out 1 — one-cycle launch pulse to `CoreTop`.
- `busy` out 1 — sequencer is not in IDLE, DONE or TIMEOUT.
- `done` out 1 — sticky: run ended by halt.
- `timeout` out 1 — sticky: run ended by watchdog.
- `cycle_count` out 32 — cycles spent in RUN and DRAIN, saturating.

## Operation
All outputs are registered. Reset values: `core_rstn`=0, `cg_clk_en`=0, `first_fetch_trigger`=0, `busy`=0, `done`=0, `timeout`=0, `cycle_count`=0; state IDLE.

States and transitions:
- **IDLE**: `start` → RESET.
- **RESET**: `core_rstn`=0, `cg_clk_en`=0. Dwell `RESET_CYCLES` cycles → SETTLE.
- **SETTLE**: `core_rstn`=1, `cg_clk_en`=1. Dwell `SETTLE_CYCLES` cycles → LAUNCH.
- **LAUNCH**: `first_fetch_trigger`=1 for exactly one cycle → RUN; watchdog cleared.
- **RUN**:
  - Watchdog increments each cycle; `wd_kick` clears it to 0.
  - `halt_req` → DRAIN.
  - Watchdog at all-ones with no kick and no halt → TIMEOUT.
- **DRAIN**: clock stays on. Dwell `DRAIN_CYCLES` cycles → DONE.
- **DONE**: `cg_clk_en`=0, `done`=1, `core_rstn` stays 1 so core state is preserved.
- **TIMEOUT**: `cg_clk_en`=0, `timeout`=1, `core_rstn` stays 1.
- From DONE or TIMEOUT, `start` clears both flags and `cycle_count` → RESET.

Priority and boundary rules:
- `start` while `busy`=1 is ignored.
- `halt_req` beats watchdog expiry in the same cycle.
- `halt_req` beats `wd_kick` in the same cycle.
- `halt_req` and `wd_kick` outside RUN are ignored.
- `cycle_count` increments in RUN and DRAIN and saturates at 0xFFFF_FFFF, no wrap.
- `rst` asserted mid-run returns all outputs to reset values immediately (asynchronous), gating the core clock off and asserting `core_rstn` low.

## Timing
- `start` sampled high at edge 0 (R=`RESET_CYCLES`, S=`SETTLE_CYCLES`):
  - `busy`=1 and `core_rstn`=0 from cycle 1.
  - `core_rstn`=1 and `cg_clk_en`=1 from cycle R+1.
  - `first_fetch_trigger`=1 in cycle R+S+1 only.
  - RUN from cycle R+S+2.
- With defaults: trigger in cycle 21, RUN from cycle 22.
- `halt_req` seen in RUN at cycle h:
  - DRAIN during cycles h+1..h+`DRAIN_CYCLES`.
  - `done`=1, `cg_clk_en`=0 and `busy`=0 at cycle h+`DRAIN_CYCLES`+1.
- No kick after LAUNCH: `timeout`=1 at RUN entry + 2^WATCHDOG_W cycles.
- A kick at cycle k defers expiry to k+2^WATCHDOG_W.

## Structure
- `core_run_pkg` holds:
  - `run_state_t` enum: IDLE, RESET, SETTLE, LAUNCH, RUN, DRAIN, DONE, TIMEOUT.
  - The 32-bit `cycle_count` width constant.
- One shared dwell counter serves RESET, SETTLE and DRAIN. Its width is `$clog2` of the largest dwell +1.
- Watchdog reuses `UpCounter` (INCREMENT_RATE=1, WIDTH=`WATCHDOG_W`):
  - `en` = state is RUN;
  - `clear` = `wd_kick` or LAUNCH;
  - `rstn` = ~`rst`.
- FSM and flag logic are local to `core_run_ctrl`.

## Test plan
- Reset then `start` at cycle 0, defaults → `core_rstn` rises at 11, `cg_clk_en` rises at 11, single trigger at 21, `busy`=1 through RUN.
- RUN, `halt_req` at RUN cycle 5 → `done`=1 and `cg_clk_en`=0 four cycles after DRAIN entry, `cycle_count`=10, `timeout`=0.
- WATCHDOG_W=4, no kicks → `timeout`=1 16 cycles after RUN entry. Kick every 10 cycles → never times out; halt ends the run normally.
- `halt_req` and watchdog expiry in the same cycle → DRAIN then `done`=1, `timeout`=0. Repeated `start` while `busy` → no effect on state or counters.
- `rst` pulsed during RUN → all outputs at reset values immediately. New `start` → full sequence restarts with `cycle_count` from 0.
